// File: rtl/input_entry_ctrl.sv
// Hex value entry controller: debounced ENTER/DEL/SUBMIT buttons build a right-aligned
// nibble register that is offered downstream over a valid/ready handshake.
module input_entry_ctrl #(
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 100000
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [3:0]                       sw_digit,
    input  logic                             btn_enter,
    input  logic                             btn_del,
    input  logic                             btn_submit,
    input  logic                             value_ready,
    output logic [4*DIGITS-1:0]              value_out,
    output logic                             value_valid,
    output logic [$clog2(DIGITS+1)-1:0]      digit_count,
    output logic                             entry_full
);
    localparam int VW   = 4 * DIGITS;
    localparam int CW   = $clog2(DIGITS + 1);
    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {S_ENTRY, S_FULL, S_OFFER} state_t;

    // Button index: 0 = ENTER, 1 = DEL, 2 = SUBMIT
    logic [2:0]      w_raw;
    logic [2:0]      r_sync1, r_sync2, r_db, r_db_q, r_pulse;
    logic [DB_W-1:0] r_cnt [3];

    state_t          r_state, w_state_nxt;
    logic [VW-1:0]   r_value, w_value_nxt;
    logic [CW-1:0]   r_count, w_count_nxt;
    logic            w_ent, w_del, w_sub;

    assign w_raw = {btn_submit, btn_del, btn_enter};

    // Sync -> debounce -> registered rising-edge pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db    <= '0;
            r_db_q  <= '0;
            r_pulse <= '0;
            for (int i = 0; i < 3; i++) r_cnt[i] <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_q  <= r_db;
            r_pulse <= r_db & ~r_db_q;
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_cnt[i] <= '0;
                end else if (r_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
                    r_db[i]  <= ~r_db[i];
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
        end
    end

    // Priority SUBMIT > DEL > ENTER; lower-priority pulses in the same cycle are dropped
    assign w_sub = r_pulse[2];
    assign w_del = r_pulse[1] & ~r_pulse[2];
    assign w_ent = r_pulse[0] & ~r_pulse[1] & ~r_pulse[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ENTRY;
            r_value <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_value <= w_value_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_value_nxt = r_value;
        w_count_nxt = r_count;
        case (r_state)
            S_ENTRY: begin
                if (w_sub) begin
                    if (r_count != '0) w_state_nxt = S_OFFER;
                end else if (w_del) begin
                    if (r_count != '0) begin
                        w_value_nxt = {4'h0, r_value[VW-1:4]};
                        w_count_nxt = r_count - 1'b1;
                    end
                end else if (w_ent) begin
                    w_value_nxt = {r_value[VW-5:0], sw_digit};
                    w_count_nxt = r_count + 1'b1;
                    if (r_count == CW'(DIGITS - 1)) w_state_nxt = S_FULL;
                end
            end
            S_FULL: begin
                if (w_sub) begin
                    w_state_nxt = S_OFFER;
                end else if (w_del) begin
                    w_value_nxt = {4'h0, r_value[VW-1:4]};
                    w_count_nxt = CW'(DIGITS - 1);
                    w_state_nxt = S_ENTRY;
                end
            end
            S_OFFER: begin
                if (value_ready) begin
                    w_value_nxt = '0;
                    w_count_nxt = '0;
                    w_state_nxt = S_ENTRY;
                end
            end
            default: w_state_nxt = S_ENTRY;
        endcase
    end

    assign value_out   = r_value;
    assign digit_count = r_count;
    assign value_valid = (r_state == S_OFFER);
    assign entry_full  = (r_count == CW'(DIGITS));

endmodule
